// File: rtl/fusion_blend_if.sv
// rtl/fusion_blend_if.sv - beat handshake, frame buses and status bundle for fusion_blend.
interface fusion_blend_if #(
  parameter int W          = 8,
  parameter int DATA_WIDTH = 128,
  parameter int CNT_W      = 19
);
  logic [1:0]            mode;
  logic [W-1:0]          threshold;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] old_frame;
  logic [DATA_WIDTH-1:0] new_frame;
  logic [DATA_WIDTH-1:0] weight;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] fused_frame;
  logic                  m_last;
  logic                  frame_done;
  logic [CNT_W-1:0]      new_count;

  modport master (
    output mode, threshold, s_valid, old_frame, new_frame, weight, m_ready,
    input  s_ready, m_valid, fused_frame, m_last, frame_done, new_count
  );

  modport slave (
    input  mode, threshold, s_valid, old_frame, new_frame, weight, m_ready,
    output s_ready, m_valid, fused_frame, m_last, frame_done, new_count
  );
endinterface

// File: rtl/fusion_blend.sv
// rtl/fusion_blend.sv - three-stage per-pixel old/new frame blender with frame framing and weight count.
module fusion_blend #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int PIXEL_WIDTH     = 8,
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = PIXEL_WIDTH * PIXELS_PER_BEAT
) (
  input logic           clk,
  input logic           areset,
  fusion_blend_if.slave bus
);
  localparam int P     = PIXELS_PER_BEAT;
  localparam int W     = PIXEL_WIDTH;
  localparam int BEATS = IMAGE_DIM * IMAGE_DIM / P;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W = $clog2(IMAGE_DIM * IMAGE_DIM) + 1;
  localparam logic [W-1:0] W_MAX = '1;
  localparam logic [2*W:0] ROUND = (2*W+1)'(1) << (W - 1);

  logic en, s_acc, m_acc, beat_last;
  logic [1:0] mode_in;
  logic [P-1:0] ge_now;
  logic [CNT_W-1:0] ge_cnt;

  logic [BW-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0] acc_q, acc_d, cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;

  logic                      v1_q, v1_d, last1_q, last1_d;
  logic [1:0]                mode1_q, mode1_d;
  logic [P-1:0][2*W-1:0]     a1_q, a1_d, b1_q, b1_d;
  logic [DATA_WIDTH-1:0]     old1_q, old1_d, new1_q, new1_d;
  logic [P-1:0]              ge1_q, ge1_d, wz1_q, wz1_d, wf1_q, wf1_d;

  logic                      v2_q, v2_d, last2_q, last2_d;
  logic [1:0]                mode2_q, mode2_d;
  logic [P-1:0][W-1:0]       soft2_q, soft2_d;
  logic [DATA_WIDTH-1:0]     old2_q, old2_d, new2_q, new2_d;
  logic [P-1:0]              ge2_q, ge2_d, wz2_q, wz2_d, wf2_q, wf2_d;

  logic                      v3_q, v3_d, last3_q, last3_d, fd_q, fd_d;
  logic [DATA_WIDTH-1:0]     fused_q, fused_d;
  logic [W-1:0]              old_px, new_px, px;

  // Frame framing: beat position, mode latched at beat 0, and per-frame weight count.
  always_comb begin
    en        = ~v3_q | bus.m_ready;
    s_acc     = bus.s_valid & en & ~areset;
    m_acc     = v3_q & bus.m_ready;
    beat_last = (beat_q == BW'(BEATS - 1));
    mode_in   = (beat_q == '0) ? bus.mode : mode_q;
    ge_now    = '0;
    ge_cnt    = '0;
    for (int i = 0; i < P; i++) begin
      ge_now[i] = bus.weight[i*W +: W] >= bus.threshold;
      ge_cnt    = ge_cnt + CNT_W'(ge_now[i]);
    end
    beat_d = beat_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    fd_d   = m_acc & last3_q;
    if (s_acc) begin
      beat_d = beat_last ? '0 : beat_q + BW'(1);
      if (beat_q == '0) mode_d = bus.mode;
      if (beat_last) begin
        cnt_d = acc_q + ge_cnt;
        acc_d = '0;
      end else begin
        acc_d = acc_q + ge_cnt;
      end
    end
  end

  // Datapath: multiply, round-and-sum, select. Every stage holds while en is low.
  always_comb begin
    v1_d = v1_q;  last1_d = last1_q;  mode1_d = mode1_q;
    a1_d = a1_q;  b1_d = b1_q;  old1_d = old1_q;  new1_d = new1_q;
    ge1_d = ge1_q;  wz1_d = wz1_q;  wf1_d = wf1_q;
    v2_d = v2_q;  last2_d = last2_q;  mode2_d = mode2_q;  soft2_d = soft2_q;
    old2_d = old2_q;  new2_d = new2_q;  ge2_d = ge2_q;  wz2_d = wz2_q;  wf2_d = wf2_q;
    v3_d = v3_q;  last3_d = last3_q;  fused_d = fused_q;
    old_px = '0;  new_px = '0;  px = '0;
    if (en) begin
      v1_d    = s_acc;
      last1_d = s_acc & beat_last;
      mode1_d = mode_in;
      old1_d  = bus.old_frame;
      new1_d  = bus.new_frame;
      ge1_d   = ge_now;
      for (int i = 0; i < P; i++) begin
        a1_d[i]  = (2*W)'(bus.old_frame[i*W +: W]) * (2*W)'(W_MAX - bus.weight[i*W +: W]);
        b1_d[i]  = (2*W)'(bus.new_frame[i*W +: W]) * (2*W)'(bus.weight[i*W +: W]);
        wz1_d[i] = bus.weight[i*W +: W] == '0;
        wf1_d[i] = bus.weight[i*W +: W] == W_MAX;
      end
      v2_d = v1_q;  last2_d = last1_q;  mode2_d = mode1_q;
      old2_d = old1_q;  new2_d = new1_q;  ge2_d = ge1_q;  wz2_d = wz1_q;  wf2_d = wf1_q;
      for (int i = 0; i < P; i++) begin
        soft2_d[i] = W'(({1'b0, a1_q[i]} + {1'b0, b1_q[i]} + ROUND) >> W);
      end
      v3_d    = v2_q;
      last3_d = last2_q;
      for (int i = 0; i < P; i++) begin
        old_px = old2_q[i*W +: W];
        new_px = new2_q[i*W +: W];
        case (mode2_q)
          2'd0:    px = wz2_q[i] ? old_px : (wf2_q[i] ? new_px : soft2_q[i]);
          2'd1:    px = ge2_q[i] ? new_px : old_px;
          2'd2:    px = old_px;
          default: px = new_px;
        endcase
        fused_d[i*W +: W] = px;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      beat_q <= '0;  acc_q <= '0;  cnt_q <= '0;  mode_q <= '0;
      v1_q <= 1'b0;  last1_q <= 1'b0;  mode1_q <= '0;  a1_q <= '0;  b1_q <= '0;
      old1_q <= '0;  new1_q <= '0;  ge1_q <= '0;  wz1_q <= '0;  wf1_q <= '0;
      v2_q <= 1'b0;  last2_q <= 1'b0;  mode2_q <= '0;  soft2_q <= '0;
      old2_q <= '0;  new2_q <= '0;  ge2_q <= '0;  wz2_q <= '0;  wf2_q <= '0;
      v3_q <= 1'b0;  last3_q <= 1'b0;  fused_q <= '0;  fd_q <= 1'b0;
    end else begin
      beat_q <= beat_d;  acc_q <= acc_d;  cnt_q <= cnt_d;  mode_q <= mode_d;
      v1_q <= v1_d;  last1_q <= last1_d;  mode1_q <= mode1_d;  a1_q <= a1_d;  b1_q <= b1_d;
      old1_q <= old1_d;  new1_q <= new1_d;  ge1_q <= ge1_d;  wz1_q <= wz1_d;  wf1_q <= wf1_d;
      v2_q <= v2_d;  last2_q <= last2_d;  mode2_q <= mode2_d;  soft2_q <= soft2_d;
      old2_q <= old2_d;  new2_q <= new2_d;  ge2_q <= ge2_d;  wz2_q <= wz2_d;  wf2_q <= wf2_d;
      v3_q <= v3_d;  last3_q <= last3_d;  fused_q <= fused_d;  fd_q <= fd_d;
    end
  end

  assign bus.s_ready     = en & ~areset;
  assign bus.m_valid     = v3_q;
  assign bus.m_last      = last3_q;
  assign bus.fused_frame = fused_q;
  assign bus.frame_done  = fd_q;
  assign bus.new_count   = cnt_q;
endmodule

// File: doc/fusion_blend.md
FUSION_BLEND -- requirements
Module: fusion_blend

Interface
REQ-001 Parameter PIXELS_PER_BEAT, default 16: pixels carried per beat.
REQ-002 Parameter PIXEL_WIDTH (W), default 8: bits per pixel and per weight.
REQ-003 Parameter IMAGE_DIM, default 512: square frame side; BEATS_PER_FRAME = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT, an integer.
REQ-004 Parameter DATA_WIDTH, default PIXEL_WIDTH*PIXELS_PER_BEAT: bus width.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1: clock; all logic on rising edge.
REQ-007 Port areset, input, 1: synchronous active-high reset.
REQ-008 Port mode, input, 2: 0 soft blend, 1 hard select, 2 pass old, 3 pass new.
REQ-009 Port threshold, input, W: hard-select threshold.
REQ-010 Port s_valid / s_ready, input / output, 1 each: input beat handshake.
REQ-011 Port old_frame, new_frame, weight, input, DATA_WIDTH each: pixel i at bits [i*W +: W].
REQ-012 Port m_valid / m_ready, output / input, 1 each: output beat handshake.
REQ-013 Port fused_frame, output, DATA_WIDTH: fused pixels.
REQ-014 Port m_last, output, 1: high on the last beat of a frame.
REQ-015 Port frame_done, output, 1: one-cycle pulse when a frame's last beat is accepted at the output.
REQ-016 Port new_count, output, clog2(IMAGE_DIM*IMAGE_DIM)+1: count of the last completed frame's pixels with weight >= threshold.

Function
REQ-017 Input beat accepted when s_valid && s_ready; output beat accepted when m_valid && m_ready.
REQ-018 Three-stage pipeline (multiply, sum, select); en = ~stage3_valid | m_ready; all stages advance only when en; s_ready = en.
REQ-019 Latency: accepted beat appears on fused_frame/m_valid exactly 3 cycles later with m_ready held high; full throughput of one beat per cycle.
REQ-020 While m_valid && ~m_ready, fused_frame, m_last and m_valid hold stable.
REQ-021 Stage 1 per pixel: a = old*(2^W-1-w), b = new*w, each 2W bits; stage 2: z = a+b+2^(W-1), 2W+1 bits; soft result = z >> W, truncated to W bits.
REQ-022 Soft mode overrides: w==0 -> old exactly; w==2^W-1 -> new exactly.
REQ-023 Hard mode: w >= threshold -> new, else old.
REQ-024 Modes 2/3: old / new pixel passed unchanged; weight still counted.
REQ-025 mode is latched on acceptance of beat 0 of each frame and applied to the whole frame; mid-frame changes ignored until the next frame.
REQ-026 Input beat counter 0..BEATS_PER_FRAME-1 increments on accepted input and wraps to 0 after the last beat; m_last travels with that beat through the pipeline.
REQ-027 Per-frame accumulator adds, per accepted input beat, the number of pixels with w >= threshold; at the last beat, new_count loads the final sum (including that beat) and the accumulator clears to 0 the same cycle.
REQ-028 frame_done asserts for the cycle after the m_last beat is accepted at the output.

Reset
REQ-029 On areset: all stage valids 0, m_valid 0, m_last 0, frame_done 0, fused_frame 0, new_count 0, beat counter 0, accumulator 0, latched mode 0.
REQ-030 Reset mid-frame discards in-flight beats; the next accepted beat is beat 0 of a new frame.
REQ-031 s_ready is 0 during reset and 1 the first cycle after reset release.

Verification
REQ-032 Soft, W=8: old=100, new=200, w=128, m_ready=1 -> fused=150 after 3 cycles.
REQ-033 Soft overrides: w=0, old=37 -> 37; w=255, new=255 -> 255 (not 254).
REQ-034 Hard, threshold=128: w=127 -> old; w=128 -> new; one frame of all w=200 -> new_count=262144, frame_done one pulse, m_last on beat 16383 only.
REQ-035 Backpressure: m_ready low for 5 cycles mid-stream -> s_ready low after the pipeline fills, no beat lost or duplicated, output order preserved.
REQ-036 Mode change to 3 at beat 100 -> frame keeps mode 0; next frame passes new.
REQ-037 areset at beat 5000 -> m_valid 0 next cycle, next frame's m_last after 16384 accepted beats, new_count stays 0 until that frame completes.
